// File: rtl/i2s_pkg.sv
// Shared constants, state encoding and slot helpers for the I2S frame controller.
package i2s_pkg;

    localparam int unsigned CNT_W      = 10;
    localparam int unsigned BCK_BIT    = 3;
    localparam int unsigned LRCK_BIT   = 9;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned SLOT_IDX_W = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // True when slot bit index b carries a data bit of a dw-bit word (b = 1..dw).
    function automatic logic bit_in_word(input logic [SLOT_IDX_W-1:0] b, input int unsigned dw);
        return (b != '0) && (32'(b) <= dw);
    endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Gated frame counter and run/drain sequencing; derives the serial clocks and
// the per-edge strobes used by the receive and transmit datapaths.
module i2s_frame_timer
    import i2s_pkg::*;
(
    input  logic                  mck,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  scki,
    output logic                  bck,
    output logic                  lrck,
    output logic                  running,
    output logic [SLOT_IDX_W-1:0] bit_idx,
    output logic [SLOT_IDX_W-1:0] bit_nx_c,
    output logic                  lr_nx_c,
    output logic                  run_nx_c,
    output logic                  rx_smp,
    output logic                  tx_upd,
    output logic                  slot_start,
    output logic                  frame_end
);

    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [BCK_BIT:0]   BCK_MID = {1'b0, {BCK_BIT{1'b1}}};

    state_e           state;
    state_e           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             counting;

    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            running <= run_nx_c;
        end
    end

    // A frame is never cut short: stopping is only taken on the 1023 -> 0 wrap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (enable) state_nx = RUN;
            end
            RUN: begin
                cnt_nx = cnt + CNT_W'(1);
                if (!enable) state_nx = (cnt == CNT_MAX) ? IDLE : DRAIN;
            end
            DRAIN: begin
                cnt_nx = cnt + CNT_W'(1);
                if (enable)               state_nx = RUN;
                else if (cnt == CNT_MAX)  state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign counting = (state != IDLE);
    assign run_nx_c = (state_nx != IDLE);

    assign scki    = cnt[0];
    assign bck     = cnt[BCK_BIT];
    assign lrck    = cnt[LRCK_BIT];
    assign bit_idx = cnt[LRCK_BIT-1:BCK_BIT+1];

    assign bit_nx_c = cnt_nx[LRCK_BIT-1:BCK_BIT+1];
    assign lr_nx_c  = cnt_nx[LRCK_BIT];

    // Strobes mark the edge about to be taken; the IDLE->RUN edge opens the left slot.
    assign rx_smp     = counting && (cnt[BCK_BIT:0] == BCK_MID);
    assign tx_upd     = counting && (&cnt[BCK_BIT:0]);
    assign frame_end  = counting && (cnt == CNT_MAX);
    assign slot_start = ((state == IDLE) && enable)
                     || (counting && (&cnt[LRCK_BIT-1:0]) && run_nx_c);

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S frame controller: serial clock generation, receive/transmit
// shifting and valid/ready sample handoff to the DSP core.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic              mck,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdin,
    output logic              sdout,
    output logic              scki,
    output logic              bck,
    output logic              lrck,
    output logic              running,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_chan,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_chan,
    output logic              tx_underrun,
    input  logic              clr_flags
);

    logic [SLOT_IDX_W-1:0] bit_idx;
    logic [SLOT_IDX_W-1:0] bit_nx_c;
    logic                  lr_nx_c;
    logic                  run_nx_c;
    logic                  rx_smp;
    logic                  tx_upd;
    logic                  slot_start;
    logic                  frame_end;

    logic                  stop_c;
    logic                  rx_take_c;
    logic                  rx_done_c;
    logic                  tx_fill_c;
    logic                  tx_shift_c;
    logic                  tx_full_nx_c;
    logic [DATA_W-1:0]     rx_shift_c;
    logic [DATA_W-1:0]     rx_sh;
    logic [DATA_W-1:0]     tx_hold;
    logic [DATA_W-1:0]     tx_sh;
    logic                  tx_full;

    i2s_frame_timer u_timer (
        .mck        (mck),
        .reset      (reset),
        .enable     (enable),
        .scki       (scki),
        .bck        (bck),
        .lrck       (lrck),
        .running    (running),
        .bit_idx    (bit_idx),
        .bit_nx_c   (bit_nx_c),
        .lr_nx_c    (lr_nx_c),
        .run_nx_c   (run_nx_c),
        .rx_smp     (rx_smp),
        .tx_upd     (tx_upd),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

    assign stop_c     = frame_end && !run_nx_c;
    assign rx_shift_c = DATA_W'({rx_sh, sdin});
    assign rx_take_c  = rx_smp && bit_in_word(bit_idx, DATA_W);
    assign rx_done_c  = rx_smp && (32'(bit_idx) == DATA_W);
    assign tx_fill_c  = tx_valid && tx_ready;
    assign tx_shift_c = tx_upd && bit_in_word(bit_nx_c, DATA_W);

    // Receive shifter and output word; a new word always replaces a pending one.
    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_chan  <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            if (rx_take_c) rx_sh <= rx_shift_c;
            if (stop_c) begin
                rx_valid <= 1'b0;
            end else if (rx_done_c) begin
                rx_data  <= rx_shift_c;
                rx_chan  <= lrck;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Holding register occupancy; the slot-start load empties it even on a same-edge fill.
    always_comb begin
        tx_full_nx_c = tx_full;
        if (stop_c || slot_start) tx_full_nx_c = 1'b0;
        else if (tx_fill_c)       tx_full_nx_c = 1'b1;
    end

    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            if (tx_fill_c && !slot_start) tx_hold <= tx_data;
            tx_full  <= tx_full_nx_c;
            tx_ready <= !tx_full_nx_c;
        end
    end

    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            tx_sh   <= '0;
            sdout   <= 1'b0;
            tx_chan <= 1'b0;
        end else begin
            if (stop_c) begin
                tx_sh <= '0;
            end else if (slot_start) begin
                if (tx_fill_c)    tx_sh <= tx_data;
                else if (tx_full) tx_sh <= tx_hold;
                else              tx_sh <= '0;
            end else if (tx_shift_c) begin
                tx_sh <= tx_sh << 1;
            end
            if (tx_upd) sdout <= tx_shift_c ? tx_sh[DATA_W-1] : 1'b0;
            tx_chan <= run_nx_c && !lr_nx_c;
        end
    end

    // Sticky flags; a clear wins over a same-edge set.
    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (clr_flags)                                   rx_overrun <= 1'b0;
            else if (rx_done_c && rx_valid && !rx_ready)     rx_overrun <= 1'b1;
            if (clr_flags)                                   tx_underrun <= 1'b0;
            else if (slot_start && !tx_fill_c && !tx_full)   tx_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl against a frame/slot-level reference model.
module tb_i2s_frame_ctrl;

    localparam int DW = 24;

    logic          mck = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          sdin = 1'b0;
    logic          sdout, scki, bck, lrck, running;
    logic [DW-1:0] rx_data;
    logic          rx_chan, rx_valid, rx_overrun;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx_chan, tx_underrun;
    logic          clr_flags = 1'b0;

    always #5 mck = ~mck;

    i2s_frame_ctrl #(.DATA_W(DW)) dut (
        .mck         (mck),
        .reset       (reset),
        .enable      (enable),
        .sdin        (sdin),
        .sdout       (sdout),
        .scki        (scki),
        .bck         (bck),
        .lrck        (lrck),
        .running     (running),
        .rx_data     (rx_data),
        .rx_chan     (rx_chan),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_chan     (tx_chan),
        .tx_underrun (tx_underrun),
        .clr_flags   (clr_flags)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: frame position plus slot-level words and flags.
    int            m_cnt;
    bit            m_run;
    bit            m_hfull, m_tready;
    logic [DW-1:0] m_hold, m_tx_word;
    bit            m_rxv, m_rxc, m_ovr, m_und;
    logic [DW-1:0] m_rxd;
    logic [DW-1:0] rx_word [2];
    bit            directed = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cnt=%0d t=%0t", tag, got, exp, m_cnt, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_run = 0; m_hfull = 0; m_tready = 0;
        m_hold = '0; m_tx_word = '0;
        m_rxv = 0; m_rxc = 0; m_ovr = 0; m_und = 0; m_rxd = '0;
    endtask

    task automatic model_update();
        bit slot, stop, fill, done;
        slot = 0; stop = 0;
        fill = tx_valid && m_tready;
        if (!m_run) begin
            if (enable) begin m_run = 1; m_cnt = 0; slot = 1; end
        end else if (m_cnt == 1023 && !enable) begin
            m_run = 0; m_cnt = 0; stop = 1;
        end else begin
            m_cnt = (m_cnt + 1) % 1024;
            slot = (m_cnt % 512 == 0);
        end
        if (m_run && m_cnt % 512 == 0 && !directed) rx_word[m_cnt / 512] = DW'($urandom);
        // transmit holding register and slot word
        if (slot) begin
            if (fill)         m_tx_word = tx_data;
            else if (m_hfull) m_tx_word = m_hold;
            else begin
                m_tx_word = '0;
                if (!clr_flags) m_und = 1;
            end
            m_hfull = 0;
        end else if (fill) begin
            m_hold = tx_data; m_hfull = 1;
        end
        if (stop) begin m_hfull = 0; m_tx_word = '0; end
        m_tready = !m_hfull;
        // receive word completes after its last bit is sampled
        done = m_run && (m_cnt % 512 == 16 * DW + 8);
        if (done) begin
            if (m_rxv && !rx_ready && !clr_flags) m_ovr = 1;
            m_rxv = 1; m_rxd = rx_word[m_cnt / 512]; m_rxc = (m_cnt >= 512);
        end else if (m_rxv && rx_ready) begin
            m_rxv = 0;
        end
        if (stop) m_rxv = 0;
        if (clr_flags) begin m_ovr = 0; m_und = 0; end
    endtask

    function automatic logic exp_sdout();
        int b;
        b = (m_cnt % 512) / 16;
        if (m_run && b >= 1 && b <= DW) return m_tx_word[DW - b];
        return 1'b0;
    endfunction

    task automatic check_all();
        chk("clocks", 32'({scki, bck, lrck, running}),
            32'({m_cnt[0], m_cnt[3], m_cnt[9], m_run}));
        chk("sdout", 32'(sdout), 32'(exp_sdout()));
        chk("tx_hs", 32'({tx_ready, tx_chan}), 32'({m_tready, m_run && (m_cnt < 512)}));
        chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
        chk("rx_word", 32'({rx_chan, rx_data}), 32'({m_rxc, m_rxd}));
        chk("flags", 32'({rx_overrun, tx_underrun}), 32'({m_ovr, m_und}));
    endtask

    task automatic drive_sdin();
        int b, ch;
        b  = (m_cnt % 512) / 16;
        ch = m_cnt / 512;
        if (m_run && b >= 1 && b <= DW) sdin = rx_word[ch][DW - b];
        else                            sdin = 1'($urandom);
    endtask

    task automatic step();
        @(posedge mck);
        if (!reset) model_update();
        #1;
        check_all();
        drive_sdin();
    endtask

    task automatic wait_cnt(input int target);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2100 && !hit; i++) begin
            step();
            hit = m_run && (m_cnt == target);
        end
        chk("wait_cnt_tmo", 32'(hit), 32'd1);
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 0;
        for (int i = 0; i < 2100 && !hit; i++) begin
            step();
            hit = !m_run;
        end
        chk("wait_idle_tmo", 32'(hit), 32'd1);
    endtask

    int sd_at  [8] = '{16, 32, 384, 400, 528, 544, 896, 912};
    bit sd_exp [8] = '{1, 0, 1, 0, 0, 1, 1, 0};

    initial begin
        model_reset();
        rx_word[0] = 24'hA5A5A5;
        rx_word[1] = 24'h123456;

        // reset held with enable high
        for (int i = 0; i < 4; i++) step();
        chk("reset_outs", 32'({sdout, scki, bck, lrck, running, rx_valid, rx_chan,
                               rx_overrun, tx_ready, tx_chan, tx_underrun}), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);

        // directed receive with consumer always ready, no transmit data
        reset = 1'b0;
        step();
        chk("underrun_start", 32'(tx_underrun), 32'd1);
        wait_cnt(392);
        chk("rx_left", 32'({rx_valid, rx_chan, rx_data}), 32'({1'b1, 1'b0, 24'hA5A5A5}));
        wait_cnt(904);
        chk("rx_right", 32'({rx_valid, rx_chan, rx_data}), 32'({1'b1, 1'b1, 24'h123456}));
        chk("no_overrun", 32'(rx_overrun), 32'd0);

        // consumer stalls for two words, then a clear races a new overrun
        step();
        rx_ready = 1'b0;
        wait_cnt(392);
        wait_cnt(904);
        chk("ovr_word", 32'(rx_data), 32'h123456);
        chk("ovr_set", 32'(rx_overrun), 32'd1);
        clr_flags = 1'b1;
        wait_cnt(392);
        chk("ovr_clr_wins", 32'(rx_overrun), 32'd0);
        clr_flags = 1'b0;
        rx_ready  = 1'b1;

        // stop mid-frame, then preload both transmit words from idle
        wait_cnt(100);
        enable = 1'b0;
        wait_idle();
        chk("stopped", 32'({running, scki, bck, lrck}), 32'd0);
        directed = 1'b0;
        tx_data = 24'h800001; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        enable = 1'b1; tx_data = 24'h7FFFFF; tx_valid = 1'b1;
        step();
        step();
        tx_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_cnt(sd_at[k]);
            chk($sformatf("sdout_at_%0d", sd_at[k]), 32'(sdout), 32'(sd_exp[k]));
        end

        // drop enable mid-frame and restore it before the wrap
        wait_cnt(100);
        enable = 1'b0;
        wait_cnt(900);
        enable = 1'b1;
        wait_cnt(1023);
        step();
        chk("no_stop", 32'(running), 32'd1);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            rx_ready  = ($urandom_range(0, 3) != 0);
            tx_valid  = ($urandom_range(0, 2) == 0);
            tx_data   = DW'($urandom);
            clr_flags = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1499) == 0) enable = !enable;
            step();
        end
        clr_flags = 1'b0;
        tx_valid  = 1'b0;

        // asynchronous reset mid-frame
        enable = 1'b1;
        wait_cnt(300);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", 32'({sdout, scki, bck, lrck, running, rx_valid, rx_overrun,
                                tx_ready, tx_chan, tx_underrun}), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rx_ready = ($urandom_range(0, 1) != 0);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_frame_ctrl.md
# i2s_frame_ctrl

Master-mode I2S frame controller for the pedal audio path. It runs from the master clock `mck` and generates `scki`, `bck` and `lrck` from one gated 10-bit frame counter. It also sequences 24-bit receive and transmit shifting, and hands parallel samples to and from the DSP core over valid/ready handshakes. Enable and disable are glitch-free: a frame is never truncated.

## Interface
- `DATA_W`, 24: sample width. Legal range 1..31.
- `mck` input 1: master clock, 49.152 MHz. All logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: request to run the serial clocks.
- `sdin` input 1: serial data from the ADC.
- `sdout` output 1: serial data to the DAC.
- `scki` output 1: codec system clock, mck/2.
- `bck` output 1: bit clock, mck/16.
- `lrck` output 1: frame clock, mck/1024. 0 = left, 1 = right.
- `running` output 1: high in RUN or DRAIN.
- `rx_data` output DATA_W: received sample.
- `rx_chan` output 1: channel of `rx_data` (0 = L, 1 = R).
- `rx_valid` output 1: `rx_data` is held until accepted.
- `rx_ready` input 1: consumer accepts.
- `rx_overrun` output 1: sticky flag.
- `tx_data` input DATA_W: sample to transmit.
- `tx_valid` input 1: producer offers `tx_data`.
- `tx_ready` output 1: holding register is empty.
- `tx_chan` output 1: channel the next loaded word will occupy.
- `tx_underrun` output 1: sticky flag.
- `clr_flags` input 1: clears both sticky flags. Takes priority over a same-cycle set.

## Operation
- Counter `cnt[9:0]`:
  - `scki` = `cnt[0]`, `bck` = `cnt[3]`, `lrck` = `cnt[9]`. All three are registered: they are bits of the counter.
  - Slot bit index `b` = `cnt[8:4]`.
- State machine:
  - IDLE: `cnt` held at 0. Go to RUN when `enable`=1.
  - RUN: `cnt` increments every cycle. Go to DRAIN when `enable`=0.
  - DRAIN: `cnt` increments. Go to IDLE on the edge where `cnt` wraps 1023 to 0. Go back to RUN if `enable`=1 before the wrap, with no gap.
- Receive (standard I2S, MSB one bck after the lrck edge):
  - `sdin` is shifted in on the edge where `cnt[3:0]` becomes 8 (bck rise), for `b` = 1..DATA_W.
  - On the edge that captures `b`=DATA_W: `rx_data` gets the shift register, `rx_chan` gets `cnt[9]`, and `rx_valid` is set.
  - `rx_valid` clears on an edge where `rx_valid`=1 and `rx_ready`=1.
  - A new word arriving while `rx_valid`=1 and `rx_ready`=0: the new word overwrites and `rx_overrun` is set.
  - A new word arriving while `rx_ready`=1: the old word is consumed, the new word is loaded, and there is no overrun.
- Transmit:
  - The holding register fills on `tx_valid`&&`tx_ready`. `tx_ready` = holding register empty.
  - On the edge where `cnt[8:0]` wraps 511 to 0 (slot start), the holding register loads into the shifter and empties.
  - If the holding register is empty at that point, the shifter loads 0 and `tx_underrun` is set.
  - A same-edge fill and load is legal: the new word goes straight to the shifter.
  - `tx_chan` = `~cnt[9]` during RUN/DRAIN, and 0 in IDLE.
  - `sdout` updates on edges where `cnt[3:0]` becomes 0 (bck fall). It drives the shifter MSB for `b`=1..DATA_W, and 0 otherwise.
- Leaving to IDLE:
  - Clears the holding register and any pending `rx_valid`.
  - Sticky flags persist.
- Reset: every output is 0, state is IDLE, `cnt`=0, all registers are empty.

## Timing
- Counter value = number of `mck` edges since entering RUN. The first RUN cycle shows `cnt`=0.
- Left `rx_valid` rises on the edge making `cnt`=392 ((24<<4)+8, for DATA_W=24). Right rises at 904.
- The first bit of a loaded word appears on `sdout` on the edge making `cnt`=16 (left) or 528 (right). The last bit is at 16·DATA_W (or +512).
- `enable` falling at any `cnt` value: clocks stop low after `cnt` 1023. `running` falls on that same edge.
- `enable` pulses while in IDLE take effect next edge. `enable` has no debounce.
- Reset mid-frame: asynchronous return to the reset values. No partial word is emitted.

## Structure
- Package `i2s_pkg`:
  - `CNT_W`=10, `BCK_BIT`=3, `LRCK_BIT`=9, `SLOT_BITS`=32.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module `i2s_frame_timer`: counter, state machine, and the decoded strobes `rx_smp`, `tx_upd`, `slot_start`, `frame_end`.
- Receive and transmit shift/handshake logic stays in the top level.

## Test plan
- Reset with `enable`=1, release reset: `scki`/`bck`/`lrck` toggle at /2, /16, /1024. Left `rx_valid` rises at `cnt`=392.
- Drive `sdin` L=24'hA5A5A5, R=24'h123456 with `rx_ready`=1: `rx_data` reads A5A5A5 with chan 0, then 123456 with chan 1. No overrun.
- Hold `rx_ready`=0 for two words: second word visible and `rx_overrun`=1. `clr_flags` asserted together with a new overrun leaves 0.
- Preload `tx_data`=24'h800001 left and 24'h7FFFFF right: `sdout` shows 1, 22 zeros, 1 in left bits 1..24, then 0 for bits 25..31. Right slot shows 0 then ones.
- No `tx_valid` before slot start: `sdout` all zero and `tx_underrun`=1.
- Deassert `enable` at `cnt`=100: clocks run to 1023 then all go 0 and `running`=0. Reassert at `cnt`=900: no stop, no gap.
